rs_lane_merge: RTL and testbench

//  Downstream of the 8-lane byte splitter and the per-lane RS encoders.
//  - Accepts 8 independent AXIS byte streams, one codeword per lane per frame.
//  - Re-interleaves them into one 64-bit AXIS stream toward the framer: lane j -> tdata[8j+7:8j].
//  - Detects lane misalignment and length errors, then resynchronises at the next codeword boundary.

---
 rtl/rs_lane_merge_pkg.sv | 16 +
 rtl/rs_lane_merge_if.sv | 24 ++
 rtl/rs_lane_merge_fifo.sv | 54 +++++
 rtl/rs_lane_merge.sv | 177 +++++++++++++++++
 tb/tb_rs_lane_merge.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_lane_merge_pkg.sv
// Shared types and widths for the 8-lane RS codeword merger.
package rs_lane_merge_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned BUS_W     = NUM_LANES * LANE_W;
  localparam int unsigned BEAT_W    = 16;

  typedef enum logic {RUN, RESYNC} merge_state_t;

  typedef struct packed {
    logic              last;
    logic [LANE_W-1:0] data;
  } lane_entry_t;

endpackage

// File: rtl/rs_lane_merge_if.sv
// Per-lane AXIS byte inputs and merged 64-bit AXIS output of the lane merger.
interface rs_lane_merge_if;
  import rs_lane_merge_pkg::*;

  logic [NUM_LANES-1:0]             s_tvalid;
  logic [NUM_LANES-1:0]             s_tready;
  logic [NUM_LANES-1:0][LANE_W-1:0] s_tdata;
  logic [NUM_LANES-1:0]             s_tlast;
  logic                             m_tvalid;
  logic                             m_tready;
  logic [BUS_W-1:0]                 m_tdata;
  logic                             m_tlast;

  modport master (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/rs_lane_merge_fifo.sv
// Synchronous per-lane FIFO of {tlast,byte}; exact full/empty, head is the oldest entry.
module lane_byte_fifo
  import rs_lane_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  lane_entry_t wdata_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output lane_entry_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lane_entry_t      mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push is accepted even when full.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rs_lane_merge.sv
// Merges 8 RS-encoded byte lanes into one 64-bit AXIS stream, with alignment/length checking.
// Optional statistics counters (frame_cnt, err_cnt) are enabled by defining MERGE_STAT_EN.
module rs_lane_merge
  import rs_lane_merge_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 255,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  rs_lane_merge_if.slave     bus,
  output logic               align_err,
  output logic               len_err
`ifdef MERGE_STAT_EN
  ,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        err_cnt
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_SAT  = {BEAT_W{1'b1}};

  lane_entry_t                      head [NUM_LANES];
  logic [NUM_LANES-1:0]             full, empty, pop, push, head_last;
  logic [NUM_LANES-1:0][LANE_W-1:0] head_data;

  merge_state_t         state_q, state_d;
  logic [NUM_LANES-1:0] done_q, done_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic [BUS_W-1:0]     m_tdata_q, m_tdata_d;
  logic                 m_tlast_q, m_tlast_d;
  logic                 align_q, align_d;
  logic                 len_q, len_d;
  logic                 emit;
  logic                 advance, heads_ok, lasts_equal;

  assign push          = bus.s_tvalid & ~full;
  assign bus.s_tready  = ~full;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    lane_entry_t wdata;
    assign wdata = '{last: bus.s_tlast[j], data: bus.s_tdata[j]};

    lane_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[j]),
      .wdata_i (wdata),
      .pop_i   (pop[j]),
      .full_o  (full[j]),
      .empty_o (empty[j]),
      .head_o  (head[j])
    );

    assign head_last[j] = head[j].last;
    assign head_data[j] = head[j].data;
  end

  assign advance     = ~m_tvalid_q | bus.m_tready;
  assign heads_ok    = ~|empty;
  assign lasts_equal = (&head_last) | ~(|head_last);

  // Merge FSM: RUN emits aligned words, RESYNC flushes each lane to its next codeword end.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    beat_d     = beat_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    align_d    = 1'b0;
    len_d      = 1'b0;
    pop        = '0;
    emit       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (advance) begin
          if (heads_ok && lasts_equal) begin
            pop        = '1;
            emit       = 1'b1;
            m_tvalid_d = 1'b1;
            m_tdata_d  = head_data;
            m_tlast_d  = head_last[0];
            if (head_last[0]) begin
              len_d  = (beat_q != LAST_BEAT);
              beat_d = '0;
            end else if (beat_q == LAST_BEAT) begin
              len_d  = 1'b1;
              beat_d = BEAT_SAT;
            end else if (beat_q != BEAT_SAT) begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end else if (heads_ok) begin
            m_tvalid_d = 1'b0;
            align_d    = 1'b1;
            done_d     = '0;
            state_d    = RESYNC;
          end else begin
            m_tvalid_d = 1'b0;
          end
        end
      end

      RESYNC: begin
        m_tvalid_d = 1'b0;
        if (&done_q) begin
          state_d = RUN;
          beat_d  = '0;
        end else begin
          pop    = ~done_q & ~empty;
          done_d = done_q | (pop & head_last);
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      done_q     <= '0;
      beat_q     <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      align_q    <= 1'b0;
      len_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      beat_q     <= beat_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      align_q    <= align_d;
      len_q      <= len_d;
    end
  end

  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;
  assign align_err    = align_q;
  assign len_err      = len_q;

`ifdef MERGE_STAT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (emit && m_tlast_d)                          frame_cnt_d = frame_cnt_q + 32'd1;
    if ((align_d || len_d) && err_cnt_q != 16'hFFFF) err_cnt_d  = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_rs_lane_merge.sv
// Scoreboard bench for rs_lane_merge with FRAME_LEN=4, FIFO_DEPTH=16.
module tb_rs_lane_merge;
  import rs_lane_merge_pkg::*;

  localparam int FL = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        len;
  } exp_t;

  logic clk;
  logic reset;
  logic align_err, len_err;
`ifdef MERGE_STAT_EN
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  rs_lane_merge_if bus();

  rs_lane_merge #(
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .align_err (align_err),
    .len_err   (len_err)
`ifdef MERGE_STAT_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb [$];
  logic [8:0] lane_q [NUM_LANES][$];
  int         n_pass, n_total;
  int         align_seen, len_seen, last_seen, words_seen;
  bit         saw_full;
  logic [63:0] obs_first;

  task automatic send_clean(input int n, input int base);
    exp_t e;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      e.data = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
        b = 8'(base + 16 * j + k);
        lane_q[j].push_back({(k == n - 1), b});
        e.data[j*8 +: 8] = b;
      end
      e.last = (k == n - 1);
      e.len  = (e.last && k != FL - 1) || (!e.last && k == FL - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run(input int budget, input bit toggle, input int st_lane,
                     input int st_a, input int st_b);
    int cyc;
    bit seen_cur, stall_bad, busy, extra;
    logic [63:0] hold_d;
    logic hold_l;
    logic [NUM_LANES-1:0] acc;
    exp_t e;
    cyc = 0; seen_cur = 0; stall_bad = 0; busy = 1; extra = 0;
    hold_d = '0; hold_l = 1'b0;
    while (busy && cyc < budget) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        if (lane_q[j].size() > 0 && !(j == st_lane && cyc >= st_a && cyc < st_b)) begin
          bus.s_tvalid[j] = 1'b1;
          bus.s_tlast[j]  = lane_q[j][0][8];
          bus.s_tdata[j]  = lane_q[j][0][7:0];
        end else begin
          bus.s_tvalid[j] = 1'b0;
          bus.s_tlast[j]  = 1'b0;
          bus.s_tdata[j]  = 8'h00;
        end
      end
      bus.m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (bus.s_tready != '1) saw_full = 1;
      acc = bus.s_tvalid & bus.s_tready;
      if (align_err) align_seen++;
      if (len_err) len_seen++;
      if (st_lane >= 0 && cyc >= st_a + 3 && cyc < st_b && bus.m_tvalid) stall_bad = 1;
      if (bus.m_tvalid) begin
        n_total++;
        if (!seen_cur) begin
          if (sb.size() == 0) begin
            $display("FAIL unexpected_word got %h, none expected", bus.m_tdata);
          end else begin
            e = sb.pop_front();
            if (bus.m_tdata !== e.data || bus.m_tlast !== e.last || len_err !== e.len)
              $display("FAIL word%0d got data=%h last=%b len_err=%b, expected data=%h last=%b len_err=%b",
                       words_seen, bus.m_tdata, bus.m_tlast, len_err, e.data, e.last, e.len);
            else n_pass++;
          end
          if (words_seen == 0) obs_first = bus.m_tdata;
          words_seen++;
          if (bus.m_tlast) last_seen++;
          seen_cur = 1;
          hold_d = bus.m_tdata;
          hold_l = bus.m_tlast;
        end else begin
          if (bus.m_tdata !== hold_d || bus.m_tlast !== hold_l || len_err !== 1'b0)
            $display("FAIL hold_stable got data=%h last=%b len_err=%b, expected data=%h last=%b len_err=0",
                     bus.m_tdata, bus.m_tlast, len_err, hold_d, hold_l);
          else n_pass++;
        end
        if (bus.m_tready) seen_cur = 0;
      end
      @(posedge clk); #1;
      for (int j = 0; j < NUM_LANES; j++)
        if (acc[j]) void'(lane_q[j].pop_front());
      cyc++;
      busy = (sb.size() != 0) || seen_cur;
      for (int j = 0; j < NUM_LANES; j++)
        if (lane_q[j].size() != 0) busy = 1;
    end
    n_total++;
    if (busy) $display("FAIL run_timeout after %0d cycles, %0d words still expected", cyc, sb.size());
    else n_pass++;
    if (st_lane >= 0) begin
      n_total++;
      if (stall_bad) $display("FAIL stall_quiet got m_tvalid=1 during stall, expected 0");
      else n_pass++;
    end
    bus.s_tvalid = '0;
    bus.m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.m_tvalid) extra = 1;
      if (align_err) align_seen++;
      if (len_err) len_seen++;
    end
    n_total++;
    if (extra) $display("FAIL extra_word got m_tvalid=1 after drain, expected 0");
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    align_seen = 0; len_seen = 0; last_seen = 0; words_seen = 0; saw_full = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0; bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== 64'h0 || bus.m_tlast !== 1'b0 ||
        align_err !== 1'b0 || len_err !== 1'b0)
      $display("FAIL reset_outputs got v=%b d=%h l=%b ae=%b le=%b, expected all 0",
               bus.m_tvalid, bus.m_tdata, bus.m_tlast, align_err, len_err);
    else n_pass++;
    n_total++;
    if (bus.s_tready !== 8'hFF) $display("FAIL reset_tready got %b, expected 11111111", bus.s_tready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_stats();
    send_clean(4, 0);
    run(100, 0, -1, 0, 0);
    n_total++;
    if (obs_first !== 64'h7060_5040_3020_1000)
      $display("FAIL basic_word0 got %h, expected 7060504030201000", obs_first);
    else n_pass++;
    n_total++;
    if (words_seen != 4 || last_seen != 1 || align_seen != 0 || len_seen != 0)
      $display("FAIL basic_counts got words=%0d lasts=%0d ae=%0d le=%0d, expected 4 1 0 0",
               words_seen, last_seen, align_seen, len_seen);
    else n_pass++;
  endtask

  task automatic test_lane_stall();
    clear_stats();
    for (int f = 0; f < 3; f++) send_clean(4, f);
    run(300, 0, 5, 6, 16);
    n_total++;
    if (words_seen != 12 || align_seen != 0 || len_seen != 0)
      $display("FAIL stall_counts got words=%0d ae=%0d le=%0d, expected 12 0 0",
               words_seen, align_seen, len_seen);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_stats();
    for (int f = 0; f < 12; f++) send_clean(4, 3 * f);
    run(800, 1, -1, 0, 0);
    n_total++;
    if (saw_full !== 1'b1) $display("FAIL bp_fifo_full got s_tready never low, expected it to drop");
    else n_pass++;
    n_total++;
    if (words_seen != 48 || last_seen != 12)
      $display("FAIL bp_counts got words=%0d lasts=%0d, expected 48 12", words_seen, last_seen);
    else n_pass++;
  endtask

  task automatic test_misalign();
    exp_t e;
    clear_stats();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < NUM_LANES; j++)
        if (!(j == 2 && k == 3))
          lane_q[j].push_back({(j == 2) ? (k == 2) : (k == 3), 8'(8'hC0 + 16 * j + k)});
    for (int k = 0; k < 2; k++) begin
      e.data = '0;
      for (int j = 0; j < NUM_LANES; j++) e.data[j*8 +: 8] = 8'(8'hC0 + 16 * j + k);
      e.last = 1'b0;
      e.len  = 1'b0;
      sb.push_back(e);
    end
    send_clean(4, 8'h05);
    run(300, 0, -1, 0, 0);
    n_total++;
    if (align_seen != 1 || len_seen != 0)
      $display("FAIL misalign_flags got ae=%0d le=%0d, expected 1 0", align_seen, len_seen);
    else n_pass++;
  endtask

  task automatic test_long_frame();
    clear_stats();
    send_clean(6, 8'h08);
    run(200, 0, -1, 0, 0);
    n_total++;
    if (len_seen != 2 || align_seen != 0 || last_seen != 1)
      $display("FAIL long_flags got le=%0d ae=%0d lasts=%0d, expected 2 0 1",
               len_seen, align_seen, last_seen);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit stray;
    clear_stats();
    bus.m_tready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        bus.s_tvalid[j] = 1'b1;
        bus.s_tlast[j]  = 1'b0;
        bus.s_tdata[j]  = 8'(8'hA0 + c);
      end
      @(posedge clk); #1;
    end
    bus.s_tvalid = '0;
    @(negedge clk);
    n_total++;
    if (bus.m_tvalid !== 1'b1) $display("FAIL pre_reset_valid got %b, expected 1", bus.m_tvalid);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bus.m_tready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.m_tvalid !== 1'b0 || bus.s_tready !== 8'hFF)
      $display("FAIL midreset_state got v=%b tready=%b, expected 0 11111111", bus.m_tvalid, bus.s_tready);
    else n_pass++;
`ifdef MERGE_STAT_EN
    n_total++;
    if (frame_cnt !== 32'd0 || err_cnt !== 16'd0)
      $display("FAIL stat_reset got frame_cnt=%0d err_cnt=%0d, expected 0 0", frame_cnt, err_cnt);
    else n_pass++;
`endif
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.m_tvalid) stray = 1;
    end
    n_total++;
    if (stray) $display("FAIL midreset_flush got m_tvalid=1 with empty inputs, expected 0");
    else n_pass++;
    @(posedge clk); #1;
    send_clean(4, 8'h02);
    run(100, 0, -1, 0, 0);
    n_total++;
    if (words_seen != 4 || len_seen != 0 || align_seen != 0)
      $display("FAIL postreset_counts got words=%0d le=%0d ae=%0d, expected 4 0 0",
               words_seen, len_seen, align_seen);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    obs_first = '0;
    clear_stats();
    test_reset();
    test_basic();
    test_lane_stall();
    test_backpressure();
    test_misalign();
    test_long_frame();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
